// File: rtl/apb_timer_pkg.sv
// Shared register offsets, CTRL field layout and prescaler helper for the APB timer.
package apb_timer_pkg;

  localparam logic [1:0] TIMER_CTRL   = 2'd0;
  localparam logic [1:0] TIMER_COUNT  = 2'd1;
  localparam logic [1:0] TIMER_CMP    = 2'd2;
  localparam logic [1:0] TIMER_STATUS = 2'd3;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_ONESHOT   = 1;
  localparam int CTRL_IRQEN     = 2;
  localparam int CTRL_PRESC_LSB = 3;
  localparam int CTRL_PRESC_MSB = 5;

  typedef struct packed {
    logic [2:0] presc;
    logic       irqen;
    logic       oneshot;
    logic       en;
  } ctrl_t;

  // Terminal value of the 8-bit prescaler counter for a given PRESC setting.
  function automatic logic [7:0] presc_mask(input logic [2:0] presc);
    return 8'((32'd1 << presc) - 32'd1);
  endfunction

endpackage

// File: rtl/apb_timer_prescaler.sv
// Divides the clock by 2^PRESC while enabled; tick_o pulses on the last count of each period.
module apb_timer_prescaler
  import apb_timer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [2:0] presc_i,
  input  logic       clr_i,
  output logic       tick_o
);

  logic [7:0] psc_q, psc_d;

  assign tick_o = en_i & (psc_q == presc_mask(presc_i));

  always_comb begin
    psc_d = psc_q;
    if (clr_i) begin
      psc_d = '0;
    end else if (en_i) begin
      psc_d = tick_o ? 8'd0 : psc_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_d;
    end
  end

endmodule

// File: rtl/apb_timer_unit.sv
// APB timer: prescaled up-counter with compare match, W1C pending flag and registered level IRQ.
module apb_timer_unit
  import apb_timer_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic [31:0]               pwdata_i,
  input  logic                      pwrite_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  output logic [31:0]               prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  output logic                      irq_o
);

  ctrl_t                ctrl_q, ctrl_d, ctrl_wdat;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] cmp_q, cmp_d;
  logic                 pend_q, pend_d;
  logic                 irq_q;

  logic       addr_err, access, wr_en;
  logic [1:0] reg_sel;
  logic       ctrl_wr, count_wr, cmp_wr, status_wr;
  logic       psc_clr, tick, match;
  logic       unused_ok;

  // Only offsets 0x0..0xC exist; anything above bit 3 is an error, byte lanes are ignored.
  assign addr_err  = |paddr_i[APB_ADDR_WIDTH-1:4];
  assign reg_sel   = paddr_i[3:2];
  assign access    = psel_i & penable_i;
  assign wr_en     = access & pwrite_i & ~addr_err;
  assign ctrl_wr   = wr_en & (reg_sel == TIMER_CTRL);
  assign count_wr  = wr_en & (reg_sel == TIMER_COUNT);
  assign cmp_wr    = wr_en & (reg_sel == TIMER_CMP);
  assign status_wr = wr_en & (reg_sel == TIMER_STATUS);
  assign ctrl_wdat = ctrl_t'(pwdata_i[CTRL_PRESC_MSB:0]);
  assign unused_ok = ^{paddr_i[1:0], pwdata_i};

  assign psc_clr = ctrl_wr & ctrl_wdat.en & ~ctrl_q.en;

  apb_timer_prescaler u_prescaler (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (ctrl_q.en),
    .presc_i (ctrl_q.presc),
    .clr_i   (psc_clr),
    .tick_o  (tick)
  );

  // A software COUNT write overrides the tick, so no match is taken on that edge.
  assign match = tick & ~count_wr & (count_q == cmp_q);

  always_comb begin
    count_d = count_q;
    if (count_wr) begin
      count_d = pwdata_i[CNT_WIDTH-1:0];
    end else if (tick) begin
      count_d = match ? '0 : count_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (match && ctrl_q.oneshot) begin
      ctrl_d.en = 1'b0;
    end
    if (ctrl_wr) begin
      ctrl_d = ctrl_wdat;
    end
  end

  assign cmp_d = cmp_wr ? pwdata_i[CNT_WIDTH-1:0] : cmp_q;

  // A new match beats a simultaneous W1C so no event is lost.
  always_comb begin
    pend_d = pend_q;
    if (status_wr && pwdata_i[0]) begin
      pend_d = 1'b0;
    end
    if (match) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q  <= '0;
      count_q <= '0;
      cmp_q   <= '0;
      pend_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      pend_q  <= pend_d;
      irq_q   <= pend_q & ctrl_q.irqen;
    end
  end

  always_comb begin
    prdata_o = '0;
    if (psel_i && !pwrite_i && !addr_err) begin
      case (reg_sel)
        TIMER_CTRL:   prdata_o[CTRL_PRESC_MSB:0] = ctrl_q;
        TIMER_COUNT:  prdata_o[CNT_WIDTH-1:0]    = count_q;
        TIMER_CMP:    prdata_o[CNT_WIDTH-1:0]    = cmp_q;
        TIMER_STATUS: prdata_o[0]                = pend_q;
      endcase
    end
  end

  assign pready_o  = 1'b1;
  assign pslverr_o = access & addr_err;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_apb_timer_unit.sv
// Directed self-checking bench for apb_timer_unit: register access, timing, collisions, reset.
module tb_apb_timer_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [11:0] paddr_i = '0;
  logic [31:0] pwdata_i = '0;
  logic        pwrite_i = 1'b0;
  logic        psel_i = 1'b0;
  logic        penable_i = 1'b0;
  logic [31:0] prdata_o;
  logic        pready_o;
  logic        pslverr_o;
  logic        irq_o;

  int checks = 0;
  int errors = 0;

  localparam logic [11:0] A_CTRL   = 12'h000;
  localparam logic [11:0] A_COUNT  = 12'h004;
  localparam logic [11:0] A_CMP    = 12'h008;
  localparam logic [11:0] A_STATUS = 12'h00C;

  apb_timer_unit #(.APB_ADDR_WIDTH(12), .CNT_WIDTH(32)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .paddr_i   (paddr_i),
    .pwdata_i  (pwdata_i),
    .pwrite_i  (pwrite_i),
    .psel_i    (psel_i),
    .penable_i (penable_i),
    .prdata_o  (prdata_o),
    .pready_o  (pready_o),
    .pslverr_o (pslverr_o),
    .irq_o     (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic setup(input logic [11:0] a, input logic wr, input logic [31:0] d);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr; paddr_i = a; pwdata_i = d;
  endtask

  task automatic to_access();
    @(posedge clk_i);
    #1 penable_i = 1'b1;
    #1;
  endtask

  task automatic to_idle();
    @(posedge clk_i);
    #1 psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
  endtask

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d, input logic err, input string tag);
    setup(a, 1'b1, d);
    to_access();
    chk(pslverr_o, err, {tag, "_slverr"});
    chk(pready_o, 1'b1, {tag, "_pready"});
    to_idle();
  endtask

  task automatic apb_read(input logic [11:0] a, input logic [31:0] exp, input logic err, input string tag);
    setup(a, 1'b0, 32'h0);
    to_access();
    chk(prdata_o, exp, tag);
    chk(pslverr_o, err, {tag, "_slverr"});
    chk(pready_o, 1'b1, {tag, "_pready"});
    to_idle();
  endtask

  // Samples a register in the setup phase (state right after the previous edge) and again in access.
  task automatic rd2(input logic [11:0] a, input logic [31:0] exp_s, input logic [31:0] exp_a, input string tag);
    setup(a, 1'b0, 32'h0);
    #1 chk(prdata_o, exp_s, {tag, "_setup"});
    to_access();
    chk(prdata_o, exp_a, {tag, "_access"});
    to_idle();
  endtask

  initial begin
    #3;
    chk(irq_o, 1'b0, "rst_irq");
    chk(pready_o, 1'b1, "rst_pready");
    chk(pslverr_o, 1'b0, "rst_slverr");
    chk(prdata_o, 32'h0, "rst_prdata");
    @(posedge clk_i); @(posedge clk_i);
    #1 rst_ni = 1'b1;
    apb_read(A_CTRL,   32'h0, 1'b0, "init_ctrl");
    apb_read(A_COUNT,  32'h0, 1'b0, "init_count");
    apb_read(A_CMP,    32'h0, 1'b0, "init_cmp");
    apb_read(A_STATUS, 32'h0, 1'b0, "init_status");
    chk(irq_o, 1'b0, "init_irq");

    // Periodic: CMP=4, PRESC=0; match on the 5th edge after EN, irq on the 6th.
    apb_write(A_CMP, 32'd4, 1'b0, "p_cmp");
    apb_write(A_CTRL, 32'h05, 1'b0, "p_ctrl");
    wait_cycles(4);
    chk(irq_o, 1'b0, "p_irq_e4");
    wait_cycles(1);
    chk(irq_o, 1'b0, "p_irq_e5");
    setup(A_COUNT, 1'b0, 32'h0);
    #1 chk(prdata_o, 32'h0, "p_count_after_match");
    to_access();
    chk(irq_o, 1'b1, "p_irq_e6");
    chk(prdata_o, 32'h1, "p_count_e6");
    to_idle();
    apb_write(A_CTRL, 32'h0, 1'b0, "p_stop");
    apb_write(A_STATUS, 32'h1, 1'b0, "p_w1c");
    apb_write(A_COUNT, 32'h0, 1'b0, "p_count0");

    // One-shot: CMP=2, PRESC=2 -> tick every 4 cycles, match 12 cycles after EN.
    apb_write(A_CMP, 32'd2, 1'b0, "o_cmp");
    apb_write(A_CTRL, 32'h13, 1'b0, "o_ctrl");
    wait_cycles(11);
    rd2(A_CTRL, 32'h13, 32'h12, "o_ctrl_en_cleared");
    apb_read(A_STATUS, 32'h1, 1'b0, "o_pend");
    apb_read(A_COUNT, 32'h0, 1'b0, "o_count");
    wait_cycles(8);
    apb_read(A_COUNT, 32'h0, 1'b0, "o_count_hold");

    // W1C colliding with a match: set wins.
    apb_write(A_STATUS, 32'h1, 1'b0, "c_w1c_pre");
    apb_read(A_STATUS, 32'h0, 1'b0, "c_pend_clear");
    apb_write(A_CMP, 32'd0, 1'b0, "c_cmp0");
    apb_write(A_CTRL, 32'h05, 1'b0, "c_ctrl");
    apb_write(A_STATUS, 32'h1, 1'b0, "c_w1c_collide");
    rd2(A_STATUS, 32'h1, 32'h1, "c_pend_set_wins");
    apb_write(A_CTRL, 32'h04, 1'b0, "c_stop");
    wait_cycles(1);
    chk(irq_o, 1'b1, "c_irq_high");
    apb_write(A_STATUS, 32'h1, 1'b0, "c_w1c");
    chk(irq_o, 1'b1, "c_irq_lags");
    wait_cycles(1);
    chk(irq_o, 1'b0, "c_irq_fall");
    apb_read(A_STATUS, 32'h0, 1'b0, "c_pend_cleared");

    // CMP write on a tick edge: match uses the old CMP (0), so COUNT stays 0.
    apb_write(A_CTRL, 32'h01, 1'b0, "m_ctrl");
    apb_write(A_CMP, 32'd5, 1'b0, "m_cmp5");
    rd2(A_COUNT, 32'h0, 32'h1, "m_old_cmp");

    // COUNT write on a tick edge: SW value wins.
    apb_write(A_CMP, 32'hFF, 1'b0, "w_cmp");
    apb_write(A_COUNT, 32'h10, 1'b0, "w_count");
    rd2(A_COUNT, 32'h10, 32'h11, "w_count_sw_wins");

    // Undecoded offset: error, write dropped, read zero; byte-lane bits ignored.
    apb_write(A_CTRL, 32'h10, 1'b0, "e_ctrl");
    apb_write(12'h010, 32'h0, 1'b1, "e_wr");
    apb_read(12'h010, 32'h0, 1'b1, "e_rd");
    apb_read(A_CTRL, 32'h10, 1'b0, "e_ctrl_kept");
    apb_read(12'h003, 32'h10, 1'b0, "e_lane_ignored");

    // Asynchronous reset with COUNT=3 and PEND=1.
    apb_write(A_CMP, 32'd0, 1'b0, "r_cmp");
    apb_write(A_CTRL, 32'h05, 1'b0, "r_run");
    apb_write(A_CTRL, 32'h04, 1'b0, "r_stop");
    apb_write(A_COUNT, 32'd3, 1'b0, "r_count");
    apb_read(A_COUNT, 32'd3, 1'b0, "r_count_rd");
    apb_read(A_STATUS, 32'h1, 1'b0, "r_pend_rd");
    chk(irq_o, 1'b1, "r_irq_before");
    #2 rst_ni = 1'b0;
    #1 chk(irq_o, 1'b0, "r_irq_async");
    @(posedge clk_i);
    #1;
    apb_read(A_CTRL,   32'h0, 1'b0, "r_ctrl");
    apb_read(A_COUNT,  32'h0, 1'b0, "r_count0");
    apb_read(A_CMP,    32'h0, 1'b0, "r_cmp0");
    apb_read(A_STATUS, 32'h0, 1'b0, "r_status0");
    rst_ni = 1'b1;
    wait_cycles(3);
    chk(irq_o, 1'b0, "r_irq_after");
    apb_read(A_COUNT, 32'h0, 1'b0, "r_count_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
